ultrasonic_presence: RTL and testbench

- Drives an HC-SR04-style ultrasonic ranger: periodic trigger pulse, echo-width measurement, conversion to centimetres.
- Produces the `distancia` presence flag consumed by the LCD message controller: low = object near, which wakes the display.
- Sits directly upstream of the LCD controller, in the main `clk` domain.

---
 rtl/ultrasonic_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/ultrasonic_presence.sv | 203 ++++++++++++++++++++
 tb/tb_ultrasonic_presence.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic presence sensor: FSM state encoding
// and default timing constants for a 50 MHz system clock.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIGGER   = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    COOLDOWN  = 3'd4
  } state_t;

  localparam int DEF_TRIG_CYCLES         = 500;      // 10 us trigger pulse
  localparam int DEF_CYCLES_PER_CM       = 2900;     // 58 us of echo per cm
  localparam int DEF_ECHO_TIMEOUT_CYCLES = 1250000;  // 25 ms echo wait
  localparam int DEF_PERIOD_CYCLES       = 3000000;  // 60 ms measurement period
  localparam int DEF_MAX_CM              = 400;
  localparam int DEF_THRESH_CM           = 20;
  localparam int DEF_DIST_BITS           = 9;
  localparam int DEF_FILTER_COUNT        = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs (echo line, keypad
// lines, ...). Asynchronous active-low reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ultrasonic_presence.sv
// HC-SR04 style ranger driver: periodic trigger, echo width measurement in
// centimetres, and the active-low `distancia` presence flag for the LCD.
// Optional build macro ULTRASONIC_FILTER_EN: distancia only changes after
// FILTER_COUNT consecutive results agree on the new near/far classification.
module ultrasonic_presence
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
  parameter int CYCLES_PER_CM       = DEF_CYCLES_PER_CM,
  parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
  parameter int PERIOD_CYCLES       = DEF_PERIOD_CYCLES,
  parameter int MAX_CM              = DEF_MAX_CM,
  parameter int THRESH_CM           = DEF_THRESH_CM,
`ifdef ULTRASONIC_FILTER_EN
  parameter int FILTER_COUNT        = DEF_FILTER_COUNT,
`endif
  parameter int DIST_BITS           = DEF_DIST_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 echo_i,
  output logic                 trig_o,
  output logic                 distancia,
  output logic [DIST_BITS-1:0] dist_cm,
  output logic                 dist_valid,
  output logic                 timeout_o
);

  localparam int CYC_W = $clog2(PERIOD_CYCLES + 1);
  localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam int CM_W  = $clog2(MAX_CM + 1);

  localparam logic [CYC_W-1:0] TRIG_LAST    = CYC_W'(TRIG_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TRIG_CYCLES + ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0] PERIOD_LAST  = CYC_W'(PERIOD_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_MAX       = CM_W'(MAX_CM);
  localparam logic [CM_W-1:0]  CM_THRESH    = CM_W'(THRESH_CM);

  state_t             state_reg, state_next;
  logic [CYC_W-1:0]   cyc_reg, cyc_next;
  logic [SUB_W-1:0]   sub_reg, sub_next;
  logic [CM_W-1:0]    cm_reg, cm_next;
  logic               trig_reg;
  logic               echo_s, echo_d_reg;
  logic               echo_rise, echo_fall;
  logic               result_fire;
  logic [CM_W-1:0]    result_cm;
  logic               result_timeout;
  logic               result_far;
  logic [DIST_BITS-1:0] dist_reg;
  logic               valid_reg;
  logic               timeout_reg;
  logic               far_reg;

  sync_2ff #(.WIDTH(1)) u_echo_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (echo_i),
    .q     (echo_s)
  );

  assign echo_rise  = echo_s & ~echo_d_reg;
  assign echo_fall  = ~echo_s & echo_d_reg;
  assign result_far = ~(result_cm < CM_THRESH);

  // State, counters, edge-detect copy and a registered (glitch-free) trigger.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      sub_reg    <= '0;
      cm_reg     <= '0;
      echo_d_reg <= 1'b0;
      trig_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      sub_reg    <= sub_next;
      cm_reg     <= cm_next;
      echo_d_reg <= echo_s;
      trig_reg   <= (state_next == TRIGGER);
    end
  end

  // Next-state logic; a result is produced on every transition into COOLDOWN.
  always_comb begin
    state_next     = state_reg;
    cyc_next       = (cyc_reg == '1) ? cyc_reg : cyc_reg + 1'b1;
    sub_next       = sub_reg;
    cm_next        = cm_reg;
    result_fire    = 1'b0;
    result_cm      = cm_reg;
    result_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        cyc_next = '0;
        if (enable_i) state_next = TRIGGER;
      end
      TRIGGER: begin
        if (cyc_reg == TRIG_LAST) state_next = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_next = MEASURE;
          sub_next   = '0;
          cm_next    = '0;
        end else if (cyc_reg == TIMEOUT_LAST) begin
          state_next     = COOLDOWN;
          result_fire    = 1'b1;
          result_cm      = CM_MAX;
          result_timeout = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          // The fall-detect cycle is the last echo-high cycle being counted,
          // so a sub-counter sitting on its last value completes one more cm.
          state_next  = COOLDOWN;
          result_fire = 1'b1;
          result_cm   = (sub_reg == SUB_LAST) ? cm_reg + 1'b1 : cm_reg;
        end else if (sub_reg == SUB_LAST) begin
          sub_next = '0;
          cm_next  = cm_reg + 1'b1;
          if (cm_reg == CM_MAX - 1'b1) begin
            state_next  = COOLDOWN;
            result_fire = 1'b1;
            result_cm   = CM_MAX;
          end
        end else begin
          sub_next = sub_reg + 1'b1;
        end
      end
      COOLDOWN: begin
        // >= guards against a measurement overrunning a misconfigured period.
        if (cyc_reg >= PERIOD_LAST) begin
          cyc_next   = '0;
          state_next = enable_i ? TRIGGER : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
    endcase
  end

  // Result registers: distance, timeout flag and the one-cycle valid strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dist_reg    <= DIST_BITS'(MAX_CM);
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      valid_reg <= result_fire;
      if (result_fire) begin
        dist_reg    <= DIST_BITS'(result_cm);
        timeout_reg <= result_timeout;
      end
    end
  end

`ifdef ULTRASONIC_FILTER_EN
  localparam int AGREE_W = (FILTER_COUNT > 1) ? $clog2(FILTER_COUNT) : 1;
  localparam logic [AGREE_W-1:0] AGREE_LAST = AGREE_W'(FILTER_COUNT - 1);

  logic [AGREE_W-1:0] agree_reg;

  // Presence flag flips only after a run of results all voting for the change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      far_reg   <= 1'b1;
      agree_reg <= '0;
    end else if (result_fire) begin
      if (result_far == far_reg) begin
        agree_reg <= '0;
      end else if (agree_reg == AGREE_LAST) begin
        far_reg   <= result_far;
        agree_reg <= '0;
      end else begin
        agree_reg <= agree_reg + 1'b1;
      end
    end
  end
`else
  // Presence flag follows every result directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      far_reg <= 1'b1;
    end else if (result_fire) begin
      far_reg <= result_far;
    end
  end
`endif

  assign trig_o     = trig_reg;
  assign distancia  = far_reg;
  assign dist_cm    = dist_reg;
  assign dist_valid = valid_reg;
  assign timeout_o  = timeout_reg;

endmodule

// File: tb/tb_ultrasonic_presence.sv
// Randomized bench for ultrasonic_presence with small timing parameters.
// Expected results come from the sensor's arithmetic: distance is
// floor(echo_width / CYCLES_PER_CM) capped at MAX_CM, results appear three
// clocks after the echo falls (or when the cap/timeout is reached), and
// triggers repeat every PERIOD_CYCLES. Build with ULTRASONIC_FILTER_EN to
// check the agreement filter on distancia.
`timescale 1ns/1ps
module tb_ultrasonic_presence;

  localparam int TRIG   = 4;
  localparam int CPM    = 10;
  localparam int TOUT   = 200;
  localparam int PERIOD = 1000;
  localparam int MAXCM  = 40;
  localparam int THRESH = 20;
  localparam int DBITS  = 9;
  localparam int FCOUNT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable_i = 1'b0;
  logic             echo_i = 1'b0;
  logic             trig_o;
  logic             distancia;
  logic [DBITS-1:0] dist_cm;
  logic             dist_valid;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int model_far = 1;
  int model_agree = 0;
  int last_trig_rise = -1;
  int last_cm = MAXCM;

  ultrasonic_presence #(
    .TRIG_CYCLES         (TRIG),
    .CYCLES_PER_CM       (CPM),
    .ECHO_TIMEOUT_CYCLES (TOUT),
    .PERIOD_CYCLES       (PERIOD),
    .MAX_CM              (MAXCM),
    .THRESH_CM           (THRESH),
    .DIST_BITS           (DBITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable_i),
    .echo_i     (echo_i),
    .trig_o     (trig_o),
    .distancia  (distancia),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference presence classification, with the optional agreement filter.
  task automatic model_result(input int cm);
    int far;
    far = (cm < THRESH) ? 0 : 1;
`ifdef ULTRASONIC_FILTER_EN
    if (far == model_far) begin
      model_agree = 0;
    end else begin
      model_agree++;
      if (model_agree == FCOUNT) begin
        model_far   = far;
        model_agree = 0;
      end
    end
`else
    model_far = far;
`endif
  endtask

  // One full measurement period: trigger, optional echo of `width` cycles
  // starting `delay` cycles after the trigger falls, result checks.
  task automatic measure(input int delay, input int width, input bit echo_en, input bit drop_enable);
    int n, t_rise, t_fall, c0, exp_cm, exp_at, pulses, pulse_at, got_cm, got_to, got_far, trig_extra;
    n = 0;
    while (trig_o !== 1'b1 && n < 3 * PERIOD) begin
      step();
      n++;
    end
    check("trig_seen", trig_o, 1);
    t_rise = cycle;
    if (last_trig_rise >= 0) check("period", t_rise - last_trig_rise, PERIOD);
    last_trig_rise = t_rise;
    n = 0;
    while (trig_o === 1'b1 && n < 10 * TRIG) begin
      step();
      n++;
    end
    check("trig_width", n, TRIG);
    t_fall = cycle;
    if (drop_enable) enable_i = 1'b0;
    c0 = t_fall + delay;
    if (echo_en) begin
      exp_cm = (width / CPM > MAXCM) ? MAXCM : width / CPM;
      exp_at = c0 + ((width < MAXCM * CPM) ? width : MAXCM * CPM) + 3;
    end else begin
      exp_cm = MAXCM;
      exp_at = t_fall + TOUT;
    end
    pulses = 0; pulse_at = -1; got_cm = -1; got_to = -1; got_far = -1; trig_extra = 0;
    while (cycle < t_rise + PERIOD - 1) begin
      if (echo_en && cycle == c0) echo_i = 1'b1;
      if (echo_en && cycle == c0 + width) echo_i = 1'b0;
      step();
      if (dist_valid === 1'b1) begin
        pulses++;
        pulse_at = cycle;
        got_cm   = int'(dist_cm);
        got_to   = int'(timeout_o);
        got_far  = int'(distancia);
      end
      if (trig_o !== 1'b0) trig_extra++;
    end
    echo_i = 1'b0;
    model_result(exp_cm);
    last_cm = exp_cm;
    check("valid_pulses", pulses, 1);
    check("valid_time", pulse_at - t_rise, exp_at - t_rise);
    check("dist_cm", got_cm, exp_cm);
    check("timeout", got_to, echo_en ? 0 : 1);
    check("distancia", got_far, model_far);
    check("trig_quiet", trig_extra, 0);
    $display("meas echo=%0d delay=%0d width=%0d -> cm=%0d timeout=%0d distancia=%0d valid@+%0d",
             echo_en, delay, width, got_cm, got_to, got_far, pulse_at - t_rise);
  endtask

  task automatic model_reset();
    model_far      = 1;
    model_agree    = 0;
    last_trig_rise = -1;
    last_cm        = MAXCM;
  endtask

  initial begin
    int n, highs;

    // Reset state, with enable already high.
    enable_i = 1'b1;
    repeat (3) step();
    check("rst_trig", trig_o, 0);
    check("rst_distancia", distancia, 1);
    check("rst_dist_cm", dist_cm, MAXCM);
    check("rst_valid", dist_valid, 0);
    check("rst_timeout", timeout_o, 0);
    @(negedge clk) reset = 1'b1;
    step();
    check("trig_after_release", trig_o, 1);

    // Directed cases.
    measure(10, 155, 1'b1, 1'b0);
    measure(20, 300, 1'b1, 1'b0);
    measure(0, 0, 1'b0, 1'b0);
    measure(30, 600, 1'b1, 1'b0);
    measure(5, 399, 1'b1, 1'b0);
    measure(5, 400, 1'b1, 1'b0);

    // Randomized measurements.
    for (int i = 0; i < 10; i++) begin
      measure(int'($urandom_range(0, 100)), int'($urandom_range(1, 600)),
              ($urandom_range(0, 4) != 0), 1'b0);
    end

    // Alternating near/far results.
    for (int i = 0; i < 6; i++) begin
      measure(8, (i % 2 == 0) ? 155 : 300, 1'b1, 1'b0);
    end

    // enable_i dropped mid-measurement: result still delivered, then parked.
    measure(5, 250, 1'b1, 1'b1);
    highs = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (trig_o !== 1'b0) highs++;
    end
    check("idle_no_trigger", highs, 0);
    check("idle_hold_cm", dist_cm, last_cm);
    check("idle_hold_far", distancia, model_far);
    enable_i = 1'b1;
    step();
    check("trig_after_enable", trig_o, 1);
    last_trig_rise = -1;
    measure(5, 155, 1'b1, 1'b0);

    // Reset pulled mid-MEASURE.
    n = 0;
    while (trig_o !== 1'b1 && n < 3 * PERIOD) begin step(); n++; end
    n = 0;
    while (trig_o === 1'b1 && n < 10 * TRIG) begin step(); n++; end
    echo_i = 1'b1;
    repeat (50) step();
    #2 reset = 1'b0;
    #1;
    check("midrst_trig", trig_o, 0);
    check("midrst_dist_cm", dist_cm, MAXCM);
    check("midrst_distancia", distancia, 1);
    check("midrst_timeout", timeout_o, 0);
    echo_i = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;

    // Reset pulled while the trigger is high must drop it immediately.
    step();
    check("trig_restart", trig_o, 1);
    #2 reset = 1'b0;
    #1;
    check("trig_async_clear", trig_o, 0);
    @(negedge clk) reset = 1'b1;
    model_reset();
    measure(15, 120, 1'b1, 1'b0);
    measure(15, 330, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
